mdu_sched: RTL and testbench

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_sched_if.sv | 30 +++
 rtl/mdu_sched.sv | 98 +++++++++
 tb/tb_mdu_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_sched_if.sv
// mdu_sched_if: E/D-stage request lines and status/hazard outputs
// shared between the pipeline controller and the mult/div scheduler.
interface mdu_sched_if;
  logic       StartE;
  logic [1:0] OpE;
  logic       DivZeroE;
  logic       exp_in;
  logic       MdUseD;
  logic       Busy;
  logic       Done;
  logic [1:0] DoneOp;
  logic [3:0] Count;
  logic       StallF;
  logic       StallD;
  logic       FlushE;

  modport master (
    output StartE, OpE, DivZeroE,
    output exp_in, MdUseD,
    input  Busy, Done, DoneOp, Count,
    input  StallF, StallD, FlushE
  );

  modport slave (
    input  StartE, OpE, DivZeroE,
    input  exp_in, MdUseD,
    output Busy, Done, DoneOp, Count,
    output StallF, StallD, FlushE
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: mult/div occupancy scheduler and HI/LO hazard stall.
// MDU_DIVZERO_SKIP_EN: divide by zero finishes after one busy cycle.
module mdu_sched (
  input logic       Clk,
  input logic       Reset,
  mdu_sched_if.slave mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] dop_q, dop_d;
  logic       done_q, done_d;
  logic       start;
  logic       stall;
  logic [3:0] div_cnt;

  assign start = mif.StartE & ~mif.exp_in
               & (state_q == IDLE);

`ifdef MDU_DIVZERO_SKIP_EN
  assign div_cnt = mif.DivZeroE ? 4'd0 : 4'd9;
`else
  logic unused_divzero;
  assign unused_divzero = mif.DivZeroE;
  assign div_cnt = 4'd9;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dop_d   = dop_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d = mif.OpE;
          if (mif.OpE[0]) begin
            state_d = DIV;
            cnt_d   = div_cnt;
          end else begin
            state_d = MULT;
            cnt_d   = 4'd4;
          end
        end
      end
      MULT, DIV: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          dop_d   = op_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Reset drops any in-flight op without a Done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      dop_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dop_q   <= dop_d;
      done_q  <= done_d;
    end
  end

  assign stall = mif.MdUseD
               & (mif.StartE | mif.Busy);

  assign mif.Busy   = (state_q != IDLE);
  assign mif.Done   = done_q;
  assign mif.DoneOp = dop_q;
  assign mif.Count  = cnt_q;
  assign mif.StallF = stall;
  assign mif.StallD = stall;
  assign mif.FlushE = stall;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed cycle-by-cycle checks of mdu_sched
// timing, hazard stall, cancel, reset and back-to-back cases.
module tb_mdu_sched;

  logic Clk;
  logic Reset;
  int   n_run;
  int   n_fail;

  mdu_sched_if mif();

  mdu_sched dut (
    .Clk  (Clk),
    .Reset(Reset),
    .mif  (mif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    mif.StartE   = 1'b0;
    mif.OpE      = 2'd0;
    mif.DivZeroE = 1'b0;
    mif.exp_in   = 1'b0;
    mif.MdUseD   = 1'b0;
  endtask

  task automatic chk_stall(
    input string tag,
    input int    exp
  );
    chk({tag, ".StallF"}, int'(mif.StallF), exp);
    chk({tag, ".StallD"}, int'(mif.StallD), exp);
    chk({tag, ".FlushE"}, int'(mif.FlushE), exp);
  endtask

  int  dz_done;
  bit  b;

  initial begin
    n_run  = 0;
    n_fail = 0;
    idle_in();
    Reset = 1'b1;
    // reset priority: start on a reset edge
    mif.StartE = 1'b1;
    nxt();
    nxt();
    #1;
    chk("rst.Busy", int'(mif.Busy), 0);
    chk("rst.Done", int'(mif.Done), 0);
    chk("rst.DoneOp", int'(mif.DoneOp), 0);
    chk("rst.Count", int'(mif.Count), 0);
    Reset = 1'b0;
    idle_in();
    nxt();
    chk("rst.idle", int'(mif.Busy), 0);

    // mult; a second start at c2 is ignored
    for (int c = 0; c <= 8; c++) begin
      idle_in();
      mif.StartE = (c == 0 || c == 2);
      mif.OpE    = (c == 2) ? 2'd1 : 2'd0;
      #1;
      b = (c >= 1 && c <= 5);
      chk($sformatf("mul.Busy@%0d", c),
          int'(mif.Busy), int'(b));
      chk($sformatf("mul.Count@%0d", c),
          int'(mif.Count), b ? 5 - c : 0);
      chk($sformatf("mul.Done@%0d", c),
          int'(mif.Done), int'(c == 6));
      if (c == 6)
        chk("mul.DoneOp", int'(mif.DoneOp), 0);
      nxt();
    end

    // signed div with stall; exp_in mid-op is ignored
    for (int c = 0; c <= 12; c++) begin
      idle_in();
      mif.StartE = (c == 0);
      mif.OpE    = 2'd3;
      mif.MdUseD = 1'b1;
      mif.exp_in = (c == 3);
      #1;
      b = (c >= 1 && c <= 10);
      chk_stall($sformatf("div.stall@%0d", c),
                int'(c <= 10));
      chk($sformatf("div.Busy@%0d", c),
          int'(mif.Busy), int'(b));
      chk($sformatf("div.Count@%0d", c),
          int'(mif.Count), b ? 10 - c : 0);
      chk($sformatf("div.Done@%0d", c),
          int'(mif.Done), int'(c == 11));
      if (c == 11)
        chk("div.DoneOp", int'(mif.DoneOp), 3);
      nxt();
    end

    // exception cancels the start
    for (int c = 0; c <= 4; c++) begin
      idle_in();
      mif.StartE = (c == 0);
      mif.exp_in = (c == 0);
      mif.MdUseD = (c == 0);
      #1;
      chk_stall($sformatf("exc.stall@%0d", c),
                int'(c == 0));
      chk($sformatf("exc.Busy@%0d", c),
          int'(mif.Busy), 0);
      chk($sformatf("exc.Done@%0d", c),
          int'(mif.Done), 0);
      nxt();
    end

    // back-to-back mult, second start on Done cycle
    for (int c = 0; c <= 13; c++) begin
      idle_in();
      mif.StartE = (c == 0 || c == 6);
      mif.OpE    = (c == 6) ? 2'd2 : 2'd0;
      #1;
      b = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
      chk($sformatf("b2b.Busy@%0d", c),
          int'(mif.Busy), int'(b));
      chk($sformatf("b2b.Done@%0d", c),
          int'(mif.Done), int'(c == 6 || c == 12));
      if (c == 12)
        chk("b2b.DoneOp", int'(mif.DoneOp), 2);
      nxt();
    end

    // reset mid-divide
    for (int c = 0; c <= 15; c++) begin
      idle_in();
      mif.StartE = (c == 0);
      mif.OpE    = 2'd1;
      Reset      = (c == 4);
      #1;
      b = (c >= 1 && c <= 4);
      chk($sformatf("rmid.Busy@%0d", c),
          int'(mif.Busy), int'(b));
      if (c == 5)
        chk("rmid.Count@5", int'(mif.Count), 0);
      chk($sformatf("rmid.Done@%0d", c),
          int'(mif.Done), 0);
      nxt();
    end
    Reset = 1'b0;

    // divide by zero
`ifdef MDU_DIVZERO_SKIP_EN
    dz_done = 2;
`else
    dz_done = 11;
`endif
    for (int c = 0; c <= 12; c++) begin
      idle_in();
      mif.StartE   = (c == 0);
      mif.OpE      = 2'd1;
      mif.DivZeroE = (c == 0);
      #1;
      b = (c >= 1 && c < dz_done);
      chk($sformatf("dz.Busy@%0d", c),
          int'(mif.Busy), int'(b));
      chk($sformatf("dz.Done@%0d", c),
          int'(mif.Done), int'(c == dz_done));
      if (c == dz_done)
        chk("dz.DoneOp", int'(mif.DoneOp), 1);
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
